// File: rtl/hr_nic_if.sv
// hr_nic_if: client and node-port signal bundle for the hierarchical-ring NIC.
interface hr_nic_if;
  logic         inj_valid;
  logic         inj_ready;
  logic [3:0]   inj_dest;
  logic [127:0] inj_data;
  logic [143:0] port_local_o;
  logic         local_ack;
  logic [143:0] port_local_i;
  logic         ej_valid;
  logic         ej_ready;
  logic [3:0]   ej_src;
  logic [3:0]   ej_tag;
  logic [127:0] ej_data;
  logic         ej_drop;
  logic         starve;
  modport master (
    output inj_valid, inj_dest, inj_data, local_ack, port_local_i, ej_ready,
    input  inj_ready, port_local_o, ej_valid, ej_src, ej_tag, ej_data, ej_drop, starve
  );
  modport slave (
    input  inj_valid, inj_dest, inj_data, local_ack, port_local_i, ej_ready,
    output inj_ready, port_local_o, ej_valid, ej_src, ej_tag, ej_data, ej_drop, starve
  );
endinterface

// File: rtl/hr_nic.sv
// hr_nic: local injection/ejection buffering between a client and one ring node port pair.
module hr_nic #(
  parameter logic [3:0] addr       = 4'b0010,
  parameter int          INJ_DEPTH  = 4,
  parameter int          EJ_DEPTH   = 2,
  parameter int          STARVE_LIM = 8
) (
  input logic  clk,
  input logic  rst,
  hr_nic_if.slave nic
);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam int WW  = $clog2(STARVE_LIM + 1);
  localparam logic [IAW:0]  INJ_FULL = (IAW+1)'(INJ_DEPTH);
  localparam logic [EAW:0]  EJ_FULL  = (EAW+1)'(EJ_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIM);
  logic [143:0]   inj_mem_q [INJ_DEPTH];
  logic [135:0]   ej_mem_q  [EJ_DEPTH];
  logic [IAW-1:0] inj_wp_q, inj_rp_q;
  logic [IAW:0]   inj_cnt_q;
  logic [EAW-1:0] ej_wp_q, ej_rp_q;
  logic [EAW:0]   ej_cnt_q;
  logic [3:0]     tag_q;
  logic [WW-1:0]  wait_q, wait_d;
  logic           ej_drop_q;
  logic           inj_push, inj_pop, ej_pop, ej_hit, ej_cap, ej_full;
  logic [135:0]   ej_head;
  logic           unused;
  assign unused = ^nic.port_local_i[3:1];
  assign nic.inj_ready    = inj_cnt_q != INJ_FULL;
  assign nic.port_local_o = (inj_cnt_q != '0) ? inj_mem_q[inj_rp_q] : '0;
  assign ej_head          = ej_mem_q[ej_rp_q];
  // Ejection outputs read as zero whenever the buffer is empty, including right after reset.
  assign nic.ej_valid = ej_cnt_q != '0;
  assign nic.ej_src   = nic.ej_valid ? ej_head[3:0]   : '0;
  assign nic.ej_tag   = nic.ej_valid ? ej_head[7:4]   : '0;
  assign nic.ej_data  = nic.ej_valid ? ej_head[135:8] : '0;
  assign nic.ej_drop  = ej_drop_q;
  assign nic.starve   = wait_q == WAIT_MAX;
  always_comb begin
    inj_push = nic.inj_valid && nic.inj_ready;
    inj_pop  = nic.local_ack && inj_cnt_q != '0;
    ej_pop   = nic.ej_valid && nic.ej_ready;
    ej_full  = ej_cnt_q == EJ_FULL;
    ej_hit   = nic.port_local_i[0] && nic.port_local_i[7:4] == addr;
    ej_cap   = ej_hit && (!ej_full || ej_pop);
    wait_d   = (inj_cnt_q == '0 || inj_pop) ? '0 : (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inj_wp_q  <= '0;
      inj_rp_q  <= '0;
      inj_cnt_q <= '0;
      ej_wp_q   <= '0;
      ej_rp_q   <= '0;
      ej_cnt_q  <= '0;
      tag_q     <= '0;
      wait_q    <= '0;
      ej_drop_q <= 1'b0;
    end else begin
      inj_wp_q  <= inj_wp_q + IAW'(inj_push);
      inj_rp_q  <= inj_rp_q + IAW'(inj_pop);
      inj_cnt_q <= inj_cnt_q + (IAW+1)'(inj_push) - (IAW+1)'(inj_pop);
      ej_wp_q   <= ej_wp_q + EAW'(ej_cap);
      ej_rp_q   <= ej_rp_q + EAW'(ej_pop);
      ej_cnt_q  <= ej_cnt_q + (EAW+1)'(ej_cap) - (EAW+1)'(ej_pop);
      tag_q     <= tag_q + 4'(inj_push);
      wait_q    <= wait_d;
      ej_drop_q <= nic.port_local_i[0] && !ej_cap;
    end
  // Payload storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem_q[inj_wp_q] <= {nic.inj_data, tag_q, addr, nic.inj_dest, 4'b0001};
    if (ej_cap) ej_mem_q[ej_wp_q] <= nic.port_local_i[143:8];
  end
endmodule

// File: tb/tb_hr_nic.sv
// tb_hr_nic: randomized and directed checks of hr_nic against a queue-based reference model.
module tb_hr_nic;
  localparam logic [3:0] ADDR = 4'b0010;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  hr_nic_if bus();
  hr_nic #(.addr(ADDR), .INJ_DEPTH(4), .EJ_DEPTH(2), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst), .nic(bus)
  );
  always #5 clk = ~clk;
  logic [143:0] m_inj[$];
  logic [135:0] m_ej[$];
  int   m_tag, m_wait;
  logic m_drop;
  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_clear();
    m_inj.delete();
    m_ej.delete();
    m_tag  = 0;
    m_wait = 0;
    m_drop = 1'b0;
  endtask
  task automatic model_step();
    int  n_inj, n_ej;
    bit  ack_pop, push, ej_pop, hit, cap;
    n_inj   = m_inj.size();
    n_ej    = m_ej.size();
    ack_pop = bus.local_ack && n_inj > 0;
    push    = bus.inj_valid && n_inj < 4;
    m_wait  = (n_inj == 0 || ack_pop) ? 0 : (m_wait >= 8 ? 8 : m_wait + 1);
    if (ack_pop) void'(m_inj.pop_front());
    if (push) begin
      m_inj.push_back({bus.inj_data, 4'(m_tag), ADDR, bus.inj_dest, 4'b0001});
      m_tag = (m_tag + 1) % 16;
    end
    ej_pop = bus.ej_ready && n_ej > 0;
    hit    = bus.port_local_i[0] && bus.port_local_i[7:4] == ADDR;
    cap    = hit && (n_ej < 2 || ej_pop);
    m_drop = bus.port_local_i[0] && !cap;
    if (ej_pop) void'(m_ej.pop_front());
    if (cap) m_ej.push_back(bus.port_local_i[143:8]);
  endtask
  task automatic compare();
    chk("inj_ready", bus.inj_ready, m_inj.size() < 4);
    chk("port_local_o", bus.port_local_o, m_inj.size() > 0 ? m_inj[0] : 144'h0);
    chk("ej_valid", bus.ej_valid, m_ej.size() > 0);
    if (m_ej.size() > 0) begin
      chk("ej_src", bus.ej_src, m_ej[0][3:0]);
      chk("ej_tag", bus.ej_tag, m_ej[0][7:4]);
      chk("ej_data", bus.ej_data, m_ej[0][135:8]);
    end
    chk("ej_drop", bus.ej_drop, m_drop);
    chk("starve", bus.starve, m_wait == 8);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    compare();
    rst = 1'b1;
    #1;
  endtask
  task automatic idle_inputs();
    bus.inj_valid    = 1'b0;
    bus.inj_dest     = '0;
    bus.inj_data     = '0;
    bus.local_ack    = 1'b0;
    bus.port_local_i = '0;
    bus.ej_ready     = 1'b0;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    idle_inputs();
    model_clear();
    #2;
    chk("reset port_local_o", bus.port_local_o, 144'h0);
    chk("reset inj_ready", bus.inj_ready, 1'b1);
    chk("reset ej_valid", bus.ej_valid, 1'b0);
    chk("reset ej_src", bus.ej_src, 4'h0);
    chk("reset ej_drop", bus.ej_drop, 1'b0);
    chk("reset starve", bus.starve, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // single injection then ack
    bus.inj_valid = 1'b1;
    bus.inj_dest  = 4'd5;
    bus.inj_data  = 128'h0123456789abcdef0123456789abcdef;
    cycle();
    idle_inputs();
    chk("t1 flit", bus.port_local_o, 144'h0123456789abcdef0123456789abcdef0251);
    bus.local_ack = 1'b1;
    cycle();
    bus.local_ack = 1'b0;
    chk("t1 after ack", bus.port_local_o, 144'h0);
    // backpressure, full and starvation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.inj_valid = 1'b1;
      bus.inj_dest  = 4'(i);
      bus.inj_data  = rnd128();
      cycle();
      if (i == 3) chk("t2 full after 4th", bus.inj_ready, 1'b0);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    chk("t2 starve at 7", bus.starve, 1'b0);
    cycle();
    chk("t2 starve at 8", bus.starve, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t2 tag order", bus.port_local_o[15:12], 4'(k));
      bus.local_ack = 1'b1;
      cycle();
      bus.local_ack = 1'b0;
    end
    chk("t2 drained", bus.port_local_o, 144'h0);
    chk("t2 starve cleared", bus.starve, 1'b0);
    // tag wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.inj_valid = 1'b1;
      bus.local_ack = 1'b1;
      bus.inj_dest  = 4'd7;
      bus.inj_data  = rnd128();
      cycle();
    end
    idle_inputs();
    chk("t3 17th tag", bus.port_local_o[15:12], 4'h0);
    bus.local_ack = 1'b1;
    cycle();
    bus.local_ack = 1'b0;
    // ejection flow control
    bus.port_local_i = {128'hfeedface_00000000_cafef00d_12345678, 16'h1821};
    for (int i = 0; i < 3; i++) cycle();
    bus.port_local_i = '0;
    chk("t4 drop on third", bus.ej_drop, 1'b1);
    chk("t4 ej_valid", bus.ej_valid, 1'b1);
    chk("t4 ej_src", bus.ej_src, 4'h8);
    chk("t4 ej_tag", bus.ej_tag, 4'h1);
    cycle();
    chk("t4 drop one cycle", bus.ej_drop, 1'b0);
    chk("t4 src held", bus.ej_src, 4'h8);
    bus.ej_ready = 1'b1;
    cycle();
    cycle();
    bus.ej_ready = 1'b0;
    chk("t4 drained", bus.ej_valid, 1'b0);
    // misroute
    bus.port_local_i = {128'h1, 16'h1851};
    cycle();
    bus.port_local_i = '0;
    chk("t5 misroute drop", bus.ej_drop, 1'b1);
    chk("t5 no capture", bus.ej_valid, 1'b0);
    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      bus.inj_valid    = 1'b1;
      bus.inj_dest     = 4'd3;
      bus.inj_data     = rnd128();
      bus.port_local_i = {rnd128(), 4'(i), 4'h9, ADDR, 4'h1};
      cycle();
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("t6 port_local_o", bus.port_local_o, 144'h0);
    chk("t6 inj_ready", bus.inj_ready, 1'b1);
    chk("t6 ej_valid", bus.ej_valid, 1'b0);
    chk("t6 ej_data", bus.ej_data, 128'h0);
    chk("t6 starve", bus.starve, 1'b0);
    model_clear();
    rst = 1'b1;
    bus.inj_valid = 1'b1;
    bus.inj_dest  = 4'd9;
    cycle();
    idle_inputs();
    chk("t6 tag restarts", bus.port_local_o[15:12], 4'h0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.inj_valid    = $urandom_range(0, 1) == 1;
      bus.inj_dest     = 4'($urandom);
      bus.inj_data     = rnd128();
      bus.local_ack    = $urandom_range(0, 2) == 0;
      bus.ej_ready     = $urandom_range(0, 2) != 0;
      bus.port_local_i = {rnd128(), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 3) != 0) ? ADDR : 4'($urandom),
                          3'($urandom), 1'($urandom)};
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
